// File: rtl/sw_reg_capture_ctrl.sv
// Purpose : Arms a single snapshot capture of the DSP sample stream from the software
//           control word. It waits for frame sync, writes LEN samples into BRAM, then
//           reports done. It also returns a status word for software polling.
// Ports   : user_clk/user_rst_n (sync, active-low); sw_reg control word;
//           sync_in/data_valid_in/data_in from the DSP; bram_we/addr/data registered
//           write port; busy/done flags; status_out {done,busy,state,0,count}.
module sw_reg_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       sw_reg,
  input  logic              sync_in,
  input  logic              data_valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status_out
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SYNC = 2'd1,
    S_CAPTURE   = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       sw_reg_q;
  logic              start_q;
  // Set once bit0 has been seen low after reset, so a start bit held high
  // through reset cannot arm the capture.
  logic              arm_ok_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     len_q, len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       status_q, status_d;

  logic              start_rise;
  logic              abort;
  logic [ADDR_W-1:0] len_field;
  logic [CW-1:0]     count_inc;
  logic [31:0]       sw_unused_bits;

  assign sw_unused_bits = sw_reg_q;
  assign start_rise     = sw_reg_q[0] & ~start_q & arm_ok_q;
  assign abort          = sw_reg_q[1];
  assign len_field      = sw_reg_q[16 +: ADDR_W];
  assign count_inc      = count_q + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (abort) begin
      // Abort wins over everything; count is kept so software can read how far it got.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_d = S_WAIT_SYNC;
            count_d = '0;
            // A zero length field means a full-depth capture.
            len_d   = (len_field == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_field};
          end
        end
        S_WAIT_SYNC: begin
          if (sync_in && data_valid_in) begin
            we_d    = 1'b1;
            addr_d  = '0;
            data_d  = data_in;
            count_d = {{ADDR_W{1'b0}}, 1'b1};
            state_d = (len_q == {{ADDR_W{1'b0}}, 1'b1}) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (data_valid_in) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            data_d  = data_in;
            count_d = count_inc;
            if (count_inc == len_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!sw_reg_q[0]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = (state_d == S_WAIT_SYNC) || (state_d == S_CAPTURE);
    done_d   = (state_d == S_DONE);
    status_d = {done_d, busy_d, state_d, 11'b0, 17'(count_d)};
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q  <= S_IDLE;
      sw_reg_q <= '0;
      start_q  <= 1'b0;
      arm_ok_q <= 1'b0;
      count_q  <= '0;
      len_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      sw_reg_q <= sw_reg;
      start_q  <= sw_reg_q[0];
      if (!sw_reg[0]) arm_ok_q <= 1'b1;
      count_q  <= count_d;
      len_q    <= len_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_data  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_sw_reg_capture_ctrl.sv
module tb_sw_reg_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] sw_reg;
  logic        sync_in;
  logic        vld;
  logic [31:0] din;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_data;
  logic        busy;
  logic        done;
  logic [31:0] status_out;

  int errors = 0;
  int checks = 0;

  sw_reg_capture_ctrl #(.DATA_W(32), .ADDR_W(10)) dut (
    .user_clk      (clk),
    .user_rst_n    (rst_n),
    .sw_reg        (sw_reg),
    .sync_in       (sync_in),
    .data_valid_in (vld),
    .data_in       (din),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_data     (bram_data),
    .busy          (busy),
    .done          (done),
    .status_out    (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sw;
    logic        sync;
    logic        vld;
    logic [31:0] din;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] dat;
    logic        busy;
    logic        done;
    logic [31:0] status;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [31:0] sw, input logic sy, input logic v,
                              input logic [31:0] d, input logic we, input logic [9:0] a,
                              input logic [31:0] dat, input logic b, input logic dn,
                              input logic [31:0] st);
    vec_t r;
    r.sw = sw; r.sync = sy; r.vld = v; r.din = d;
    r.we = we; r.addr = a; r.dat = dat; r.busy = b; r.done = dn; r.status = st;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Address and data are only meaningful on a write cycle.
  task automatic check_out(input string tag, input logic we, input logic [9:0] a,
                           input logic [31:0] d, input logic b, input logic dn,
                           input logic [31:0] st);
    chk({tag, ".we"}, 32'(bram_we), 32'(we));
    if (we) begin
      chk({tag, ".addr"}, 32'(bram_addr), 32'(a));
      chk({tag, ".data"}, bram_data, d);
    end
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".status"}, status_out, st);
  endtask

  task automatic drive(input logic [31:0] sw, input logic sy, input logic v, input logic [31:0] d);
    sw_reg = sw; sync_in = sy; vld = v; din = d;
  endtask

  initial begin
    // Basic LEN=4 capture, valid every cycle, then release of the start bit.
    vecs[0] = mk(32'h0000_0000, 0, 0, 32'h0,         0, 10'd0, 32'h0,         0, 0, 32'h0000_0000);
    vecs[1] = mk(32'h0004_0001, 0, 0, 32'h0,         0, 10'd0, 32'h0,         0, 0, 32'h0000_0000);
    vecs[2] = mk(32'h0004_0001, 0, 0, 32'h0,         0, 10'd0, 32'h0,         1, 0, 32'h5000_0000);
    vecs[3] = mk(32'h0004_0001, 1, 1, 32'hA5A5_0000, 1, 10'd0, 32'hA5A5_0000, 1, 0, 32'h6000_0001);
    vecs[4] = mk(32'h0004_0001, 0, 1, 32'hA5A5_0001, 1, 10'd1, 32'hA5A5_0001, 1, 0, 32'h6000_0002);
    vecs[5] = mk(32'h0004_0001, 0, 1, 32'hA5A5_0002, 1, 10'd2, 32'hA5A5_0002, 1, 0, 32'h6000_0003);
    vecs[6] = mk(32'h0004_0001, 0, 1, 32'hA5A5_0003, 1, 10'd3, 32'hA5A5_0003, 0, 1, 32'hB000_0004);
    vecs[7] = mk(32'h0004_0001, 0, 1, 32'hA5A5_0004, 0, 10'd0, 32'h0,         0, 1, 32'hB000_0004);
    vecs[8] = mk(32'h0004_0000, 0, 0, 32'h0,         0, 10'd0, 32'h0,         0, 1, 32'hB000_0004);
    vecs[9] = mk(32'h0000_0000, 0, 0, 32'h0,         0, 10'd0, 32'h0,         0, 0, 32'h0000_0004);

    // Reset with every control bit high.
    rst_n = 1'b0;
    drive(32'hFFFF_FFFF, 1, 1, 32'hDEAD_BEEF);
    repeat (5) tick();
    check_out("reset", 0, 10'd0, 32'h0, 0, 0, 32'h0);
    chk("reset.addr", 32'(bram_addr), 32'h0);
    chk("reset.data", bram_data, 32'h0);

    // Start still high after release must not arm.
    rst_n = 1'b1;
    drive(32'h0004_0001, 1, 1, 32'h1234_5678);
    repeat (4) tick();
    check_out("held_start", 0, 10'd0, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].sw, vecs[i].sync, vecs[i].vld, vecs[i].din);
      tick();
      check_out($sformatf("basic[%0d]", i), vecs[i].we, vecs[i].addr, vecs[i].dat,
                vecs[i].busy, vecs[i].done, vecs[i].status);
    end

    // Gapped valid, LEN=3: valid pattern 1,0,0,1,0,1.
    drive(32'h0003_0001, 0, 0, 0); tick(); tick();
    check_out("gap.arm", 0, 10'd0, 32'h0, 1, 0, 32'h5000_0000);
    drive(32'h0003_0001, 1, 1, 32'hB000_0010); tick();
    check_out("gap.w0", 1, 10'd0, 32'hB000_0010, 1, 0, 32'h6000_0001);
    drive(32'h0003_0001, 0, 0, 32'hBAD0_0001); tick();
    check_out("gap.idle1", 0, 10'd0, 32'h0, 1, 0, 32'h6000_0001);
    tick();
    check_out("gap.idle2", 0, 10'd0, 32'h0, 1, 0, 32'h6000_0001);
    drive(32'h0003_0001, 0, 1, 32'hB000_0011); tick();
    check_out("gap.w1", 1, 10'd1, 32'hB000_0011, 1, 0, 32'h6000_0002);
    drive(32'h0003_0001, 0, 0, 32'hBAD0_0002); tick();
    check_out("gap.idle3", 0, 10'd0, 32'h0, 1, 0, 32'h6000_0002);
    drive(32'h0003_0001, 0, 1, 32'hB000_0012); tick();
    check_out("gap.w2", 1, 10'd2, 32'hB000_0012, 0, 1, 32'hB000_0003);
    drive(32'h0000_0000, 0, 0, 0); tick(); tick();
    check_out("gap.rel", 0, 10'd0, 32'h0, 0, 0, 32'h0000_0003);

    // Abort after 5 writes of a LEN=8 capture.
    drive(32'h0008_0001, 0, 0, 0); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      drive(32'h0008_0001, (i == 0), 1, 32'hC0DE_0000 + i); tick();
      check_out($sformatf("abort.w%0d", i), 1, 10'(i), 32'hC0DE_0000 + i, 1, 0,
                32'h6000_0000 + 32'(i + 1));
    end
    drive(32'h0008_0003, 0, 0, 0); tick();
    check_out("abort.reg", 0, 10'd0, 32'h0, 1, 0, 32'h6000_0005);
    drive(32'h0008_0003, 0, 1, 32'hBAD0_0003); tick();
    check_out("abort.hit", 0, 10'd0, 32'h0, 0, 0, 32'h0000_0005);
    drive(32'h0008_0002, 1, 1, 32'hBAD0_0004); tick();
    drive(32'h0008_0003, 1, 1, 32'hBAD0_0005); tick(); tick(); tick();
    check_out("abort.toggle", 0, 10'd0, 32'h0, 0, 0, 32'h0000_0005);
    drive(32'h0000_0000, 0, 0, 0); tick(); tick();
    check_out("abort.clear", 0, 10'd0, 32'h0, 0, 0, 32'h0000_0005);

    // Sync without valid, then sync during capture, LEN=4.
    drive(32'h0004_0001, 0, 0, 0); tick(); tick();
    check_out("sync.arm", 0, 10'd0, 32'h0, 1, 0, 32'h5000_0000);
    drive(32'h0004_0001, 1, 0, 32'hBAD0_0006); tick();
    check_out("sync.novld", 0, 10'd0, 32'h0, 1, 0, 32'h5000_0000);
    drive(32'h0004_0001, 1, 1, 32'hD000_0000); tick();
    check_out("sync.w0", 1, 10'd0, 32'hD000_0000, 1, 0, 32'h6000_0001);
    drive(32'h0004_0001, 1, 1, 32'hD000_0001); tick();
    check_out("sync.w1", 1, 10'd1, 32'hD000_0001, 1, 0, 32'h6000_0002);
    drive(32'h0004_0001, 0, 1, 32'hD000_0002); tick();
    check_out("sync.w2", 1, 10'd2, 32'hD000_0002, 1, 0, 32'h6000_0003);
    drive(32'h0004_0001, 1, 1, 32'hD000_0003); tick();
    check_out("sync.w3", 1, 10'd3, 32'hD000_0003, 0, 1, 32'hB000_0004);
    drive(32'h0000_0000, 0, 0, 0); tick(); tick();

    // Reset in the middle of a capture.
    drive(32'h0004_0001, 0, 0, 0); tick(); tick();
    drive(32'h0004_0001, 1, 1, 32'hE000_0000); tick();
    check_out("midrst.w0", 1, 10'd0, 32'hE000_0000, 1, 0, 32'h6000_0001);
    rst_n = 1'b0;
    drive(32'h0004_0001, 0, 1, 32'hE000_0001); tick();
    check_out("midrst.rst", 0, 10'd0, 32'h0, 0, 0, 32'h0);
    rst_n = 1'b1;
    drive(32'h0000_0000, 0, 0, 0); tick(); tick();

    // Full-depth capture: LEN field 0 means 1024 samples, count must not wrap.
    drive(32'h0000_0001, 0, 0, 0); tick(); tick();
    check_out("full.arm", 0, 10'd0, 32'h0, 1, 0, 32'h5000_0000);
    for (int i = 0; i < 1024; i++) begin
      drive(32'h0000_0001, (i == 0), 1, 32'hF000_0000 + i); tick();
      check_out($sformatf("full[%0d]", i), 1, 10'(i), 32'hF000_0000 + i,
                (i != 1023), (i == 1023),
                (i == 1023) ? 32'hB000_0400 : 32'h6000_0000 + 32'(i + 1));
    end
    drive(32'h0000_0001, 0, 1, 32'hBAD0_0007); tick();
    check_out("full.hold", 0, 10'd0, 32'h0, 0, 1, 32'hB000_0400);
    drive(32'h0000_0000, 0, 0, 0); tick(); tick();
    check_out("full.rel", 0, 10'd0, 32'h0, 0, 0, 32'h0000_0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
